// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory handshake and retire counter
module multicycle_control_unit #(
    parameter int OPCODE_W  = 6,
    parameter int FUNCT_W   = 6,
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                mem_req,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegRead,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegDst,
    output logic                Branch,
    output logic                ALUSrc,
    output logic                PCSrc,
    output logic                MemToReg,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_R, C_JR, C_IALU, C_BR, C_J, C_JAL, C_LOAD, C_STORE
    } class_t;

    state_t                state, state_nx;
    class_t                cls;
    logic [OPCODE_W-1:0]   op_q;
    logic [FUNCT_W-1:0]    fn_q;
    logic [TIMEOUT_W-1:0]  wait_cnt, wait_nx;
    logic                  latch, waiting, retire, go;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            op_q        <= '0;
            fn_q        <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else if (!stall) begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (latch) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (instr_done)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        cls = C_ILL;
        case (op_q)
            OPCODE_W'(6'h00): cls = (fn_q == FUNCT_W'(6'h08)) ? C_JR : C_R;
            OPCODE_W'(6'h02): cls = C_J;
            OPCODE_W'(6'h03): cls = C_JAL;
            OPCODE_W'(6'h04), OPCODE_W'(6'h05): cls = C_BR;
            OPCODE_W'(6'h08), OPCODE_W'(6'h09), OPCODE_W'(6'h0A), OPCODE_W'(6'h0B),
            OPCODE_W'(6'h0C), OPCODE_W'(6'h0D), OPCODE_W'(6'h0E), OPCODE_W'(6'h0F): cls = C_IALU;
            OPCODE_W'(6'h20), OPCODE_W'(6'h21), OPCODE_W'(6'h23), OPCODE_W'(6'h24),
            OPCODE_W'(6'h25): cls = C_LOAD;
            OPCODE_W'(6'h28), OPCODE_W'(6'h29), OPCODE_W'(6'h2B): cls = C_STORE;
            default: cls = C_ILL;
        endcase
    end

    // Every strobe that commits state (writes, pulses) is qualified by go so a stall is a true freeze.
    always_comb begin
        go          = !stall;
        state_nx    = state;
        wait_nx     = '0;
        latch       = 1'b0;
        waiting     = 1'b0;
        retire      = 1'b0;
        mem_req     = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegRead     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        ALUSrc      = 1'b0;
        PCSrc       = 1'b0;
        MemToReg    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite  = go;
                    PCWrite  = go;
                    latch    = 1'b1;
                    state_nx = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (cls == C_ILL) begin
                    illegal_op = go;
                    state_nx   = S_FETCH;
                end else begin
                    RegRead  = 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_R:     begin RegDst = 1'b1; state_nx = S_WB; end
                    C_IALU:  begin ALUSrc = 1'b1; state_nx = S_WB; end
                    C_JR:    begin PCSrc = 1'b1; PCWrite = go; retire = 1'b1; end
                    C_BR:    begin Branch = 1'b1; retire = 1'b1; end
                    C_J:     begin PCSrc = 1'b1; PCWrite = go; retire = 1'b1; end
                    C_JAL:   begin PCSrc = 1'b1; PCWrite = go; RegWrite = go; retire = 1'b1; end
                    C_LOAD, C_STORE: begin ALUSrc = 1'b1; state_nx = S_MEM; end
                    default: state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = (cls == C_LOAD);
                MemWrite = (cls == C_STORE) && go;
                if (mem_ready) begin
                    if (cls == C_STORE) retire = 1'b1;
                    else state_nx = S_WB;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = go;
                RegDst   = (cls == C_R);
                MemToReg = (cls == C_LOAD);
                retire   = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
        // A ready in the same cycle as a full counter never reaches here, so ready wins.
        if (waiting) begin
            if (&wait_cnt) begin
                mem_timeout = go;
                state_nx    = S_FETCH;
            end else begin
                wait_nx = wait_cnt + TIMEOUT_W'(1);
            end
        end
        if (retire) begin
            instr_done = go;
            state_nx   = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed-vector bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [14:0] MREQ = 15'h4000, IRW = 15'h2000, PCW = 15'h1000, RR  = 15'h0800,
                            RW   = 15'h0400, MRD = 15'h0200, MWR = 15'h0100, RD  = 15'h0080,
                            BR   = 15'h0040, AS  = 15'h0020, PCS = 15'h0010, MTR = 15'h0008,
                            DN   = 15'h0004, ILL = 15'h0002, TO  = 15'h0001;
    localparam logic [14:0] FR = MREQ | MRD | IRW | PCW;
    localparam logic [14:0] FW = MREQ | MRD;
    localparam logic [14:0] MM = MREQ | AS | MRD;

    logic       clk, reset_n, mem_ready, stall;
    logic [5:0] opcode, funct;
    logic       mem_req, IRWrite, PCWrite, RegRead, RegWrite, MemRead, MemWrite, RegDst;
    logic       Branch, ALUSrc, PCSrc, MemToReg, instr_done, illegal_op, mem_timeout;
    logic [3:0] instr_count;
    logic [14:0] obs;
    logic [3:0]  exp_count;
    int          n_checks, n_pass;

    multicycle_control_unit #(
        .OPCODE_W(6), .FUNCT_W(6), .TIMEOUT_W(2), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .stall(stall), .mem_req(mem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegRead(RegRead), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegDst(RegDst), .Branch(Branch), .ALUSrc(ALUSrc),
        .PCSrc(PCSrc), .MemToReg(MemToReg), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_count(instr_count)
    );

    assign obs = {mem_req, IRWrite, PCWrite, RegRead, RegWrite, MemRead, MemWrite, RegDst,
                  Branch, ALUSrc, PCSrc, MemToReg, instr_done, illegal_op, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; mem_ready = 1'b0; stall = 1'b0; opcode = '0; funct = '0;
        tick();
        tick();
        n_checks++;
        if (obs !== FW) $display("FAIL reset_outputs: got %b expected %b", obs, FW);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", instr_count);
        else n_pass++;
        reset_n   = 1'b1;
        exp_count = 4'd0;
    endtask

    task automatic test_sequences;
        logic [14:0] ev [8];
        logic [7:0]  rdy, stl;
        logic [5:0]  op, fn;
        int          len;
        bit          ret;
        string       name;
        for (int s = 0; s < 11; s++) begin
            for (int k = 0; k < 8; k++) ev[k] = '0;
            rdy = 8'hFF; stl = 8'h00; fn = 6'h00; ret = 1'b1;
            case (s)
                0:  begin name = "rtype";   op = 6'h00; fn = 6'h20; len = 4;
                          ev[0] = FR; ev[1] = RR; ev[2] = RD; ev[3] = RW | RD | DN; end
                1:  begin name = "lw_wait"; op = 6'h23; len = 8; rdy = 8'hC7;
                          ev[0] = FR; ev[1] = RR; ev[2] = AS; ev[3] = MM; ev[4] = MM;
                          ev[5] = MM; ev[6] = MM; ev[7] = RW | MTR | DN; end
                2:  begin name = "sw";      op = 6'h2B; len = 4;
                          ev[0] = FR; ev[1] = RR; ev[2] = AS; ev[3] = MREQ | AS | MWR | DN; end
                3:  begin name = "beq";     op = 6'h04; len = 3;
                          ev[0] = FR; ev[1] = RR; ev[2] = BR | DN; end
                4:  begin name = "jal";     op = 6'h03; len = 3;
                          ev[0] = FR; ev[1] = RR; ev[2] = PCS | PCW | RW | DN; end
                5:  begin name = "jr";      op = 6'h00; fn = 6'h08; len = 3;
                          ev[0] = FR; ev[1] = RR; ev[2] = PCS | PCW | DN; end
                6:  begin name = "lui";     op = 6'h0F; len = 4;
                          ev[0] = FR; ev[1] = RR; ev[2] = AS; ev[3] = RW | DN; end
                7:  begin name = "illegal"; op = 6'h3F; len = 2; ret = 1'b0;
                          ev[0] = FR; ev[1] = ILL; end
                8:  begin name = "mem_tmo"; op = 6'h20; len = 7; rdy = 8'h07; ret = 1'b0;
                          ev[0] = FR; ev[1] = RR; ev[2] = AS; ev[3] = MM; ev[4] = MM;
                          ev[5] = MM; ev[6] = MM | TO; end
                9:  begin name = "stall";   op = 6'h00; fn = 6'h25; len = 7; stl = 8'h31;
                          ev[0] = FW; ev[1] = FR; ev[2] = RR; ev[3] = RD; ev[4] = RD;
                          ev[5] = RD; ev[6] = RW | RD | DN; end
                default: begin name = "fetch_tmo"; op = 6'h00; len = 4; rdy = 8'h00; ret = 1'b0;
                          ev[0] = FW; ev[1] = FW; ev[2] = FW; ev[3] = FW | TO; end
            endcase
            opcode = op;
            funct  = fn;
            for (int c = 0; c < len; c++) begin
                mem_ready = rdy[c];
                stall     = stl[c];
                #1;
                n_checks++;
                if (obs !== ev[c])
                    $display("FAIL %s cyc%0d: got %b expected %b", name, c + 1, obs, ev[c]);
                else n_pass++;
                tick();
            end
            if (ret) exp_count = exp_count + 4'd1;
            mem_ready = 1'b0;
            stall     = 1'b0;
            #1;
            n_checks++;
            if (obs !== FW) $display("FAIL %s back_to_fetch: got %b expected %b", name, obs, FW);
            else n_pass++;
            n_checks++;
            if (instr_count !== exp_count)
                $display("FAIL %s count: got %0d expected %0d", name, instr_count, exp_count);
            else n_pass++;
        end
    endtask

    task automatic test_count_wrap;
        opcode = 6'h04; funct = 6'h00; mem_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            tick();
            exp_count = exp_count + 4'd1;
            n_checks++;
            if (instr_count !== exp_count)
                $display("FAIL wrap_count iter%0d: got %0d expected %0d", i, instr_count, exp_count);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1; stall = 1'b0;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs !== MM) $display("FAIL mid_in_memory: got %b expected %b", obs, MM);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== FW) $display("FAIL mid_reset_outputs: got %b expected %b", obs, FW);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL mid_reset_count: got %0d expected 0", instr_count);
        else n_pass++;
        tick();
        reset_n   = 1'b1;
        exp_count = 4'd0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== FR) $display("FAIL mid_restart_fetch: got %b expected %b", obs, FR);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_sequences();
        test_count_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
